// File: rtl/panda_risc_v_if_res_fifo_if.sv
// Valid/ready stream carrying one fetch result: {PC, predecode, inst} data plus its msg bits.
interface panda_risc_v_if_res_fifo_if #(
    parameter int DATA_WIDTH = 128,
    parameter int MSG_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0] data;
    logic [MSG_WIDTH-1:0]  msg;
    logic                  valid;
    logic                  ready;

    modport master (output data, output msg, output valid, input ready);
    modport slave  (input data, input msg, input valid, output ready);
endinterface

// File: rtl/panda_risc_v_if_res_fifo.sv
// Fetch-result queue between the IFU and decode: first-word-fall-through FIFO with
// single-cycle flush and occupancy status for fetch throttling.
module panda_risc_v_if_res_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_WIDTH = 128,
    parameter int MSG_WIDTH  = 4,
    parameter int AFULL_TH   = 3
) (
    input  logic                           clk,
    input  logic                           sys_rst,
    input  logic                           flush_req,
    panda_risc_v_if_res_fifo_if.slave      s_if_res,
    panda_risc_v_if_res_fifo_if.master     m_dcd,
    output logic [$clog2(FIFO_DEPTH):0]    buf_cnt,
    output logic                           buf_full,
    output logic                           buf_empty,
    output logic                           buf_afull
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [MSG_WIDTH-1:0]  mem_msg  [FIFO_DEPTH];
    logic [AW:0]           wptr;
    logic [AW:0]           rptr;
    logic                  wr;
    logic                  rd;

    // Extra MSB on each pointer distinguishes full from empty when the LSBs match.
    assign buf_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign buf_empty = (wptr == rptr);
    assign buf_cnt   = wptr - rptr;
    assign buf_afull = (buf_cnt >= (AW+1)'(AFULL_TH));

    assign s_if_res.ready = !buf_full && !flush_req;
    assign m_dcd.valid    = !buf_empty && !flush_req;
    assign m_dcd.data     = mem_data[rptr[AW-1:0]];
    assign m_dcd.msg      = mem_msg[rptr[AW-1:0]];

    assign wr = s_if_res.valid && s_if_res.ready;
    assign rd = m_dcd.valid && m_dcd.ready;

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush_req) begin
            rptr <= wptr;
        end else begin
            if (wr) wptr <= wptr + (AW+1)'(1);
            if (rd) rptr <= rptr + (AW+1)'(1);
        end
    end

    // Entry storage is deliberately not reset; contents are only observed behind m_dcd.valid.
    always_ff @(posedge clk) begin
        if (!sys_rst && wr) begin
            mem_data[wptr[AW-1:0]] <= s_if_res.data;
            mem_msg[wptr[AW-1:0]]  <= s_if_res.msg;
        end
    end
endmodule
